// File: rtl/asi_marb.sv
`default_nettype none
// ------------------------------------------------------------------
// asi_marb : N-channel burst arbiter and user-memory port multiplexer
// Rev 1.0
// ------------------------------------------------------------------
module asi_marb #(
   parameter int NCH        = 4,
   parameter int AXI_AW     = 40,
   parameter int AXI_DW     = 128,
   parameter int AXI_WSTRBW = AXI_DW/8,
   parameter int SLV_WS     = 1,
   parameter int ARB_MODE   = 1,
   parameter int STARVE_LIM = 16,
   parameter int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                      usr_clk,
   input  logic                      usr_reset_n,
   input  logic [NCH-1:0]            ch_req,
   input  logic [NCH-1:0]            ch_last,
   input  logic [NCH-1:0]            ch_we,
   input  logic [NCH-1:0]            ch_re,
   input  logic [NCH*AXI_AW-1:0]     ch_addr,
   input  logic [NCH*AXI_DW-1:0]     ch_wdata,
   input  logic [NCH*AXI_WSTRBW-1:0] ch_wstrb,
   output logic [NCH-1:0]            ch_gnt,
   output logic [IW-1:0]             gnt_idx,
   output logic [AXI_AW-1:0]         usr_a,
   output logic                      usr_ce,
   output logic [AXI_DW-1:0]         usr_d,
   output logic [AXI_WSTRBW-1:0]     usr_we,
   input  logic [AXI_DW-1:0]         usr_q,
   output logic                      r_valid,
   output logic [AXI_DW-1:0]         r_data,
   output logic [IW-1:0]             r_tag,
   output logic                      proto_err
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [NCH-1:0] gnt_q, gnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           proto_err_q, proto_err_d;
   logic [NCH-1:0] elig;
   logic [IW-1:0]  win_idx;
   logic           win_hit, load;
   logic           gnt_any, last_hit, we_g, re_g, rd_issue;

   assign gnt_any  = |gnt_q;
   assign last_hit = |(ch_last & gnt_q);
   assign we_g     = gnt_any & ch_we[idx_q];
   assign re_g     = gnt_any & ch_re[idx_q];
   assign rd_issue = re_g & ~we_g;

   generate
      if (ARB_MODE == 1) begin : g_rr
         logic [IW-1:0] ptr_q;
         logic [IW:0]   pos;
         logic [IW:0]   nxt;

         // The finishing channel is excluded so a busy peer always gets a turn.
         assign elig = (NCH > 1) ? (ch_req & ~gnt_q) : ch_req;
         assign nxt  = {1'b0, win_idx} + (IW+1)'(1);

         always_comb begin
            win_idx = '0;
            win_hit = 1'b0;
            pos     = '0;
            for (int k = NCH-1; k >= 0; k--) begin
               pos = {1'b0, ptr_q} + (IW+1)'(k);
               if (pos >= (IW+1)'(NCH)) pos = pos - (IW+1)'(NCH);
               if (elig[pos[IW-1:0]]) begin
                  win_idx = pos[IW-1:0];
                  win_hit = 1'b1;
               end
            end
         end

         always_ff @(posedge usr_clk) begin
            if (!usr_reset_n)
               ptr_q <= '0;
            else if (load)
               ptr_q <= (nxt >= (IW+1)'(NCH)) ? '0 : nxt[IW-1:0];
         end
      end else begin : g_fixed
         localparam int CW = $clog2(STARVE_LIM + 1);
         logic [CW-1:0] cnt_q [NCH];
         logic [IW-1:0] low_idx, st_idx;
         logic          low_hit, st_hit;

         assign elig = ch_req;

         always_comb begin
            low_idx = '0;
            low_hit = 1'b0;
            st_idx  = '0;
            st_hit  = 1'b0;
            for (int i = NCH-1; i >= 0; i--) begin
               if (elig[i]) begin
                  low_idx = IW'(i);
                  low_hit = 1'b1;
               end
               if (elig[i] && cnt_q[i] == CW'(STARVE_LIM)) begin
                  st_idx = IW'(i);
                  st_hit = 1'b1;
               end
            end
            win_idx = st_hit ? st_idx : low_idx;
            win_hit = low_hit;
         end

         always_ff @(posedge usr_clk) begin
            for (int i = 0; i < NCH; i++) begin
               if (!usr_reset_n || (load && win_idx == IW'(i)))
                  cnt_q[i] <= '0;
               else if (ch_req[i] && !gnt_q[i] && cnt_q[i] != CW'(STARVE_LIM))
                  cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_hit) begin
               load    = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (last_hit) begin
               if (win_hit) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         gnt_d = NCH'(1) << win_idx;
         idx_d = win_idx;
      end
   end

   // A granted channel must not read and write together; nobody else may access at all.
   assign proto_err_d = proto_err_q | (|((ch_we | ch_re) & ~gnt_q)) | (we_g & re_g);

   always_ff @(posedge usr_clk) begin
      if (!usr_reset_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         idx_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         idx_q       <= idx_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign ch_gnt    = gnt_q;
   assign gnt_idx   = idx_q;
   assign proto_err = proto_err_q;
   assign usr_a     = gnt_any ? ch_addr[int'(idx_q)*AXI_AW +: AXI_AW] : '0;
   assign usr_d     = gnt_any ? ch_wdata[int'(idx_q)*AXI_DW +: AXI_DW] : '0;
   assign usr_we    = ch_wstrb[int'(idx_q)*AXI_WSTRBW +: AXI_WSTRBW] & {AXI_WSTRBW{we_g}};
   assign usr_ce    = we_g | re_g;
   assign r_data    = usr_q;

   generate
      if (SLV_WS == 0) begin : g_rd_comb
         assign r_valid = rd_issue;
         assign r_tag   = rd_issue ? idx_q : '0;
      end else begin : g_rd_pipe
         logic          vld_q [SLV_WS];
         logic [IW-1:0] tag_q [SLV_WS];

         always_ff @(posedge usr_clk) begin
            if (!usr_reset_n) begin
               for (int s = 0; s < SLV_WS; s++) begin
                  vld_q[s] <= 1'b0;
                  tag_q[s] <= '0;
               end
            end else begin
               vld_q[0] <= rd_issue;
               tag_q[0] <= rd_issue ? idx_q : '0;
               for (int s = 1; s < SLV_WS; s++) begin
                  vld_q[s] <= vld_q[s-1];
                  tag_q[s] <= tag_q[s-1];
               end
            end
         end

         assign r_valid = vld_q[SLV_WS-1];
         assign r_tag   = tag_q[SLV_WS-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_asi_marb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_asi_marb : directed self-checking bench, RR and fixed-priority instances
// Rev 1.0
// ------------------------------------------------------------------
module tb_asi_marb;

   localparam int NCH = 4;
   localparam int AW  = 40;
   localparam int DW  = 128;
   localparam int SW  = 16;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ch_req, ch_last, ch_we, ch_re;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic [NCH*SW-1:0] ch_wstrb;
   logic [DW-1:0]     usr_q;

   logic [NCH-1:0] rr_gnt, fx_gnt;
   logic [IW-1:0]  rr_idx, fx_idx, rr_tag, fx_tag;
   logic [AW-1:0]  rr_a, fx_a;
   logic           rr_ce, fx_ce, rr_rv, fx_rv, rr_perr, fx_perr;
   logic [DW-1:0]  rr_d, fx_d, rr_rd, fx_rd;
   logic [SW-1:0]  rr_we, fx_we;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] fx_exp [11] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4};

   always #5 clk = ~clk;

   asi_marb #(.NCH(NCH), .AXI_AW(AW), .AXI_DW(DW), .SLV_WS(2), .ARB_MODE(1), .STARVE_LIM(16)) u_rr (
      .usr_clk(clk), .usr_reset_n(rst_n), .ch_req(ch_req), .ch_last(ch_last),
      .ch_we(ch_we), .ch_re(ch_re), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
      .ch_gnt(rr_gnt), .gnt_idx(rr_idx), .usr_a(rr_a), .usr_ce(rr_ce), .usr_d(rr_d),
      .usr_we(rr_we), .usr_q(usr_q), .r_valid(rr_rv), .r_data(rr_rd), .r_tag(rr_tag),
      .proto_err(rr_perr)
   );

   asi_marb #(.NCH(NCH), .AXI_AW(AW), .AXI_DW(DW), .SLV_WS(1), .ARB_MODE(0), .STARVE_LIM(4)) u_fx (
      .usr_clk(clk), .usr_reset_n(rst_n), .ch_req(ch_req), .ch_last(ch_last),
      .ch_we(ch_we), .ch_re(ch_re), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
      .ch_gnt(fx_gnt), .gnt_idx(fx_idx), .usr_a(fx_a), .usr_ce(fx_ce), .usr_d(fx_d),
      .usr_we(fx_we), .usr_q(usr_q), .r_valid(fx_rv), .r_data(fx_rd), .r_tag(fx_tag),
      .proto_err(fx_perr)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      ch_req   = '0;
      ch_last  = '0;
      ch_we    = '0;
      ch_re    = '0;
      ch_addr  = '0;
      ch_wdata = '0;
      ch_wstrb = '0;
      usr_q    = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_in();
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      clear_in();
      step();
      step();
      // reset state
      chk("rst_rr_gnt",  rr_gnt,  0);
      chk("rst_rr_idx",  rr_idx,  0);
      chk("rst_rr_a",    rr_a,    0);
      chk("rst_rr_ce",   rr_ce,   0);
      chk("rst_rr_d",    rr_d,    0);
      chk("rst_rr_we",   rr_we,   0);
      chk("rst_rr_rv",   rr_rv,   0);
      chk("rst_rr_tag",  rr_tag,  0);
      chk("rst_rr_perr", rr_perr, 0);
      chk("rst_fx_gnt",  fx_gnt,  0);
      chk("rst_fx_rv",   fx_rv,   0);
      chk("rst_fx_perr", fx_perr, 0);
      rst_n = 1'b1;

      // round robin, all requesting, 2-beat bursts
      ch_req = 4'hF;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("rr_beat1_gnt", rr_gnt, 4'h1 << (k % 4));
         chk("rr_beat1_idx", rr_idx, k % 4);
         ch_last = '0;
         step();
         chk("rr_beat2_gnt", rr_gnt, 4'h1 << (k % 4));
         ch_last = 4'h1 << (k % 4);
         step();
      end
      chk("rr_after_gnt", rr_gnt, 4'h2);
      ch_req  = '0;
      ch_last = 4'h2;
      step();
      chk("rr_idle_gnt", rr_gnt, 4'h0);
      chk("rr_perr_clean", rr_perr, 0);

      // stray ch_last, then simultaneous write+read on granted ch0
      do_reset();
      ch_req = 4'h1;
      step();
      chk("ng_gnt0", rr_gnt, 4'h1);
      ch_last = 4'h8;
      step();
      chk("ng_last_gnt", rr_gnt, 4'h1);
      chk("ng_last_perr", rr_perr, 0);
      ch_last = '0;
      ch_we   = 4'h1;
      ch_re   = 4'h1;
      ch_wstrb[0 +: SW] = 16'hF0F0;
      ch_wdata[0 +: DW] = 128'h0123_4567_89AB_CDEF;
      ch_addr[0 +: AW]  = 40'h55;
      #1;
      chk("wr_usr_we", rr_we, 16'hF0F0);
      chk("wr_usr_ce", rr_ce, 1);
      chk("wr_usr_d",  rr_d,  128'h0123_4567_89AB_CDEF);
      chk("wr_usr_a",  rr_a,  40'h55);
      step();
      chk("wr_perr_set", rr_perr, 1);
      ch_we = '0;
      ch_re = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("wr_no_rvalid", rr_rv, 0);
         chk("wr_perr_sticky", rr_perr, 1);
      end

      // read return with SLV_WS=2, grant moves to ch3 meanwhile
      do_reset();
      ch_req = 4'hA;
      step();
      chk("rd_gnt1", rr_gnt, 4'h2);
      ch_re    = 4'h2;
      ch_wstrb = '1;
      ch_addr[1*AW +: AW] = 40'h10;
      #1;
      chk("rd_a0",  rr_a,  40'h10);
      chk("rd_ce0", rr_ce, 1);
      chk("rd_we0", rr_we, 0);
      chk("rd_rv0", rr_rv, 0);
      step();
      ch_addr[1*AW +: AW] = 40'h20;
      ch_last = 4'h2;
      #1;
      chk("rd_a1",  rr_a,  40'h20);
      chk("rd_rv1", rr_rv, 0);
      step();
      chk("rd_gnt3", rr_gnt, 4'h8);
      ch_re   = '0;
      ch_last = '0;
      ch_req  = 4'h8;
      usr_q   = 128'hAAAA_0001;
      #1;
      chk("rd_rv_b0",  rr_rv,  1);
      chk("rd_tag_b0", rr_tag, 1);
      chk("rd_dat_b0", rr_rd,  128'hAAAA_0001);
      step();
      usr_q = 128'hBBBB_0002;
      #1;
      chk("rd_rv_b1",  rr_rv,  1);
      chk("rd_tag_b1", rr_tag, 1);
      chk("rd_dat_b1", rr_rd,  128'hBBBB_0002);
      step();
      chk("rd_rv_end", rr_rv, 0);
      chk("rd_perr",   rr_perr, 0);

      // fixed priority with starvation promotion (limit 4)
      do_reset();
      ch_req  = 4'h5;
      ch_last = 4'h5;
      for (int e = 0; e < 11; e++) begin
         step();
         chk("fx_gnt_seq", fx_gnt, fx_exp[e]);
      end
      chk("fx_idx_ch2", fx_idx, 2);
      chk("fx_perr", fx_perr, 0);

      // reset mid-burst with a read issued in the reset cycle
      do_reset();
      ch_req = 4'h1;
      step();
      chk("mr_gnt0", fx_gnt, 4'h1);
      ch_re = 4'h1;
      ch_addr[0 +: AW] = 40'h30;
      rst_n = 1'b0;
      step();
      ch_re  = '0;
      ch_req = '0;
      chk("mr_gnt_drop", fx_gnt, 0);
      chk("mr_idx",      fx_idx, 0);
      chk("mr_rv",       fx_rv,  0);
      step();
      chk("mr_rv_flush", fx_rv, 0);
      rst_n  = 1'b1;
      ch_req = 4'h4;
      #1;
      chk("mr_gnt_wait", fx_gnt, 0);
      step();
      chk("mr_gnt2", fx_gnt, 4'h4);
      chk("mr_idx2", fx_idx, 2);
      chk("mr_rv2",  fx_rv,  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
